// File: rtl/mem_wb_skid_register_if.sv
// MEM/WB stage handshake bundle: upstream payload in, writeback head out.
// slave = stage view, master = producer/consumer view.
interface mem_wb_skid_register_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_address;
  logic [DATA_W-1:0] in_value;
  logic [REG_W-1:0]  in_rd;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_address;
  logic [DATA_W-1:0] out_value;
  logic [REG_W-1:0]  out_rd;
  logic              out_mem_to_reg;
  logic              out_reg_write;
  logic [DATA_W-1:0] out_wb_data;
  logic [CNT_W-1:0]  retired_count;

  modport slave (
    input  in_valid, in_address, in_value, in_rd,
    input  in_mem_to_reg, in_reg_write, out_ready,
    output in_ready, out_valid, out_address, out_value,
    output out_rd, out_mem_to_reg, out_reg_write,
    output out_wb_data, retired_count
  );

  modport master (
    output in_valid, in_address, in_value, in_rd,
    output in_mem_to_reg, in_reg_write, out_ready,
    input  in_ready, out_valid, out_address, out_value,
    input  out_rd, out_mem_to_reg, out_reg_write,
    input  out_wb_data, retired_count
  );
endinterface

// File: rtl/mem_wb_skid_register.sv
// MEM/WB pipeline stage with 2-entry skid buffer, flush, wb-data select,
// x0 write suppression and retired counter. Ports: clk, rst_n, flush, bus.
module mem_wb_skid_register #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int SUPPRESS_X0 = 1,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  mem_wb_skid_register_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] value;
    logic [REG_W-1:0]  rd;
    logic              mem_to_reg;
    logic              reg_write;
  } payload_t;

  state_t           r_state;
  state_t           w_state_nxt;
  payload_t         r_main;
  payload_t         r_skid;
  payload_t         w_main_nxt;
  payload_t         w_skid_nxt;
  payload_t         w_in;
  logic [CNT_W-1:0] r_count;
  logic             w_valid;
  logic             w_ready;
  logic             w_accept;
  logic             w_drain;
  logic             w_x0;
  logic [DATA_W-1:0] w_wb_sel;

  assign w_in = '{
    address:    bus.in_address,
    value:      bus.in_value,
    rd:         bus.in_rd,
    mem_to_reg: bus.in_mem_to_reg,
    reg_write:  bus.in_reg_write
  };

  // Both handshake flags come from registered state only.
  assign w_valid  = (r_state != S_EMPTY);
  assign w_ready  = (r_state != S_FULL);
  assign w_accept = bus.in_valid & w_ready;
  assign w_drain  = w_valid & bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (1'b1)
      (r_state == S_EMPTY): begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = w_in;
        end
      end
      (r_state == S_ONE): begin
        if (w_accept && w_drain) begin
          w_main_nxt = w_in;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
          w_skid_nxt  = w_in;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
        end
      end
      (r_state == S_FULL): begin
        if (w_drain) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Payloads may go stale here; only the state says what is valid.
    if (flush) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // A drain in a flush cycle was still consumed by writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_drain) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign w_x0     = (SUPPRESS_X0 != 0) && (r_main.rd == '0);
  assign w_wb_sel = r_main.mem_to_reg ? r_main.value
                                      : r_main.address[DATA_W-1:0];

  assign bus.in_ready       = w_ready;
  assign bus.out_valid      = w_valid;
  assign bus.out_address    = r_main.address;
  assign bus.out_value      = r_main.value;
  assign bus.out_rd         = r_main.rd;
  assign bus.out_mem_to_reg = r_main.mem_to_reg;
  assign bus.out_reg_write  = w_valid & r_main.reg_write & ~w_x0;
  assign bus.out_wb_data    = w_valid ? w_wb_sel : '0;
  assign bus.retired_count  = r_count;

endmodule

// File: doc/mem_wb_skid_register.md
Name: mem_wb_skid_register

Overview:
- Parametrised MEM/WB pipeline stage between data-memory access and register-file writeback.
- Holds one instruction's writeback payload: ALU result/address, memory load value, destination register, memToReg, regWrite.
- Adds what a plain pipeline register lacks:
  - valid/ready handshake on both sides, with a 2-entry skid buffer so back-pressure never drops data;
  - synchronous flush;
  - writeback-data select;
  - x0 write suppression;
  - a retired-instruction counter.

Parameters:
- ADDR_W, 64, width of ALU result / address field.
- DATA_W, 32, width of memory load value and writeback data; must be <= ADDR_W.
- REG_W, 5, width of destination register index.
- SUPPRESS_X0, 1, when 1, regWrite is masked for rd == 0.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  upstream (MEM) payload valid.
- in_ready  out  1  stage can accept a payload this cycle.
- in_address  in  ADDR_W  ALU result / effective address.
- in_value  in  DATA_W  data-memory load value.
- in_rd  in  REG_W  destination register.
- in_mem_to_reg  in  1  1 = write back load value, 0 = ALU result.
- in_reg_write  in  1  instruction writes the register file.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback consumes head this cycle.
- out_address  out  ADDR_W  head ALU result.
- out_value  out  DATA_W  head load value.
- out_rd  out  REG_W  head destination register.
- out_mem_to_reg  out  1  head memToReg.
- out_reg_write  out  1  qualified write enable.
- out_wb_data  out  DATA_W  selected writeback data.
- retired_count  out  CNT_W  number of entries consumed by writeback.

Behaviour:
- Storage: head register (main) plus skid register, each with a valid bit.
  - State EMPTY: no entry held.
  - State ONE: main valid.
  - State FULL: main and skid valid.
- Reset (rst_n low, asynchronous):
  - state goes to EMPTY; all payload registers and retired_count go to 0.
  - Outputs during reset: out_valid=0, out_reg_write=0, out_wb_data=0, in_ready=1.
- Handshake events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - in_ready = !(state == FULL). It is decoded from registered state only; there is no combinational path from out_ready.
  - out_valid = (state != EMPTY). All out_* fields come from main.
- Transitions (flush=0):
  - EMPTY: accept -> ONE, main <= in.
  - ONE: accept&drain -> ONE, main <= in. accept&!drain -> FULL, skid <= in. !accept&drain -> EMPTY. Otherwise hold.
  - FULL: drain -> ONE, main <= skid. No accept is possible. Otherwise hold.
- Latency: accepted payload appears on out_* the cycle after acceptance when the stage was EMPTY or draining. Full throughput is 1 entry/cycle when out_ready is held high.
- Flush:
  - Highest priority: next state EMPTY.
  - A same-cycle accept is discarded.
  - A same-cycle drain still counts as retired, because writeback consumed it this cycle.
  - Payload registers may hold stale values but must not be visible as valid.
- Data held while out_valid & !out_ready: every out_* field is stable until drain.
- out_reg_write = out_valid & main.reg_write & !(SUPPRESS_X0 && main.rd == 0).
- out_wb_data:
  - main.mem_to_reg ? main.value : main.address[DATA_W-1:0] (low bits; upper address bits ignored).
  - Forced to 0 when !out_valid.
- retired_count:
  - Increments by 1 on every drain.
  - Wraps modulo 2^CNT_W with no saturation and no flag.
- Reset asserted mid-operation: entries are lost immediately; there is no partial transfer.

Test Plan:
- Reset, then in_valid=1 with address=0x10, value=0xAB, rd=3, memToReg=1, regWrite=1, out_ready=1 -> next cycle out_valid=1, out_wb_data=0xAB, out_reg_write=1, out_rd=3; retired_count=1 one cycle later.
- Stream 4 payloads with out_ready=0 -> in_ready drops after 2 accepts (FULL); set out_ready=1 -> the 2 held payloads emerge in order on consecutive cycles, then the 3rd and 4th follow, with none lost or duplicated.
- FULL, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed payload never appears; retired_count unchanged when out_ready=0.
- Payload rd=0, regWrite=1, SUPPRESS_X0=1 -> out_reg_write=0 while out_valid=1. The same payload with SUPPRESS_X0=0 -> out_reg_write=1.
- memToReg=0, address=0xFFFF_FFFF_1234_5678 -> out_wb_data=0x1234_5678.
- CNT_W=4, 17 drains -> retired_count=1 (wrap). Drop rst_n mid-stream with FULL -> out_valid=0, retired_count=0 asynchronously, before the next clk edge.
